fixed_div: RTL and testbench
============================

// Module: fixed_div
// PURPOSE
//  Sequential signed fixed-point divider Y = A / B, the inverse operation of the equalizer's Mult.
//  Formats are the same as Mult: two's complement, WIDTH bits, FRAC fraction bits (default Q7.8).
//  Sign-magnitude restoring division produces one quotient bit per clock, with a start/done handshake.
//  Used for gain normalisation in the equalizer datapath.
// PARAMETERS
//  WIDTH  16  operand/result width, bits
//  FRAC    8  fraction bits of A, B, Y
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; sampled only in IDLE
//  A       in   WIDTH  dividend, captured on accepted start
//  B       in   WIDTH  divisor, captured on accepted start
//  busy    out  1      high from the edge that accepts start until done
//  done    out  1      one-cycle pulse; Y/ovf/dz valid from this cycle on
//  Y       out  WIDTH  quotient, held until the next done
//  ovf     out  1      result saturated (magnitude overflow)
//  dz      out  1      divide by zero
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy, done, ovf, dz = 0; Y = 0. Reset mid-operation aborts silently.
//  States: IDLE -> DIV (ITER=WIDTH+FRAC cycles) -> FIX (1 cycle) -> IDLE.
//  IDLE: if start=1, capture |A|<<FRAC (WIDTH+FRAC bits), |B|, sign=A[msb]^B[msb], dz=(B==0); busy<=1.
//   Magnitude of 0x8000 is 32768, so the magnitude path is unsigned WIDTH bits.
//  DIV: restoring step per edge: rem={rem,next dividend bit}; if rem>=|B|, rem-=|B| and qbit=1.
//   A step counter runs 0..ITER-1.
//  FIX: apply sign; saturate; register Y, ovf, dz; done<=1; busy<=0.
//  Latency is fixed: done is high after edge ITER+1 counted from the accepting edge (25 for defaults).
//   This holds for dz too.
//  Saturation: positive q > 2^(WIDTH-1)-1 -> Y=0x7FFF, ovf=1; negative q > 2^(WIDTH-1) -> Y=0x8000, ovf=1.
//  dz: Y=0x7FFF if A>=0, else Y=0x8000; dz=1, ovf=0.
//  Zero result is always +0; a negative sign with q=0 gives Y=0.
//  start while busy: ignored, no queuing. start in the done cycle: ignored (state is IDLE on the next edge).
//  done is never high for two consecutive cycles; A/B changes after capture have no effect.
// CONFIGURATION
//  FIXED_DIV_ROUND_EN defined: round to nearest, half away from zero, using one extra compare in FIX:
//   if 2*rem >= |B|, q+=1 before saturation.
//  Undefined: truncate toward zero. Latency is identical in both builds.
// STRUCTURE
//  Shared header eq_fixed_defs.vh: WIDTH/FRAC defaults, Q-format MAX/MIN constants (0x7FFF/0x8000),
//   state encodings IDLE/DIV/FIX. Mult uses the same constants.
//  Sub-module sat_fixed: combinational sign-apply + saturate, (sign, q[WIDTH+FRAC-1:0]) -> (Y, ovf).
//   Reusable by Mult.
// TESTING (Q7.8, defaults; check done exactly 25 edges after start, busy high throughout)
//  A=0x0300 (3.0), B=0x0200 (2.0) -> Y=0x0180, ovf=0, dz=0.
//  A=0xFD00 (-3.0), B=0x0200 -> Y=0xFE80 (-1.5).
//   A=0x8000, B=0x0100 -> Y=0x8000, ovf=0 (exact negative limit).
//  A=0x7FFF, B=0x0001 -> Y=0x7FFF, ovf=1.
//   A=0x8000, B=0x0000 -> Y=0x8000, dz=1, ovf=0, same latency.
//  A=0x0200, B=0x0300 -> Y=0x00AA truncated; Y=0x00AB with FIXED_DIV_ROUND_EN.
//   A=0x0000, B=0xFF00 -> Y=0x0000.
//  Pulse start again at edge 5 with different A/B -> ignored; Y is the first operation's result.
//   Start in the done cycle -> ignored.
//  rst_n=0 at edge 10 of an operation -> busy=done=ovf=dz=0, Y=0 immediately (async).
//   After release, a new start -> correct result; back-to-back ops give one done pulse each.

Source files
------------

// File: rtl/fixed_div_pkg.sv
// Shared definitions for the fixed-point divider and its saturation helper.
//   DEF_WIDTH / DEF_FRAC : default Q7.8 format (16 bits, 8 fraction bits)
//   Q_MAX_DEF / Q_MIN_DEF: saturation limits of the default format
//   div_state_e          : divider sequencing states IDLE -> DIV -> FIX
package fixed_div_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_FRAC  = 8;

  localparam logic [DEF_WIDTH-1:0] Q_MAX_DEF = 16'h7FFF;
  localparam logic [DEF_WIDTH-1:0] Q_MIN_DEF = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/fixed_div_sat_fixed.sv
// sat_fixed: combinational sign-apply and saturation of an unsigned magnitude.
//   sign  in  1           result is negative when set
//   q     in  WIDTH+FRAC  unsigned quotient magnitude
//   Y     out WIDTH       two's complement result, clamped to MAX/MIN
//   ovf   out 1           magnitude did not fit and Y was clamped
// A negative sign with q=0 yields +0 since the negation of zero is zero.
module sat_fixed #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic                  sign,
  input  logic [WIDTH+FRAC-1:0] q,
  output logic [WIDTH-1:0]      Y,
  output logic                  ovf
);

  localparam int unsigned QW = WIDTH + FRAC;

  // Largest magnitudes representable for each sign: 2^(W-1)-1 and 2^(W-1).
  localparam logic [QW-1:0]    POS_LIM = {{(FRAC+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [QW-1:0]    NEG_LIM = {{FRAC{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] Y_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Y_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    ovf = 1'b0;
    Y   = q[WIDTH-1:0];
    if (!sign) begin
      if (q > POS_LIM) begin
        Y   = Y_MAX;
        ovf = 1'b1;
      end
    end else begin
      if (q > NEG_LIM) begin
        Y   = Y_MIN;
        ovf = 1'b1;
      end else begin
        Y = -q[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fixed_div.sv
// fixed_div: sequential signed fixed-point divider Y = A / B (sign-magnitude,
// restoring, one quotient bit per clock). Fixed latency: done rises after edge
// WIDTH+FRAC+1 counted from the edge that accepts start, divide-by-zero included.
//   clk, rst_n   clock and asynchronous active-low reset
//   start        request, accepted only in IDLE and not in the done cycle
//   A, B         dividend / divisor, captured on the accepting edge
//   busy         high from the accepting edge until done
//   done         one-cycle pulse; Y/ovf/dz valid from then until the next done
//   Y, ovf, dz   quotient, saturation flag, divide-by-zero flag
// Build option: FIXED_DIV_ROUND_EN selects round-half-away-from-zero; the
// default build truncates toward zero.
module fixed_div
  import fixed_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             ovf,
  output logic             dz
);

  localparam int unsigned ITER = WIDTH + FRAC;
  localparam int unsigned QW   = ITER;
  localparam int unsigned CW   = $clog2(ITER);

  localparam logic [WIDTH-1:0] Y_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Y_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [QW-1:0]    dq_q;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] bmag_q;
  logic             sign_q;
  logic             aneg_q;
  logic             bzero_q;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] y_q;
  logic             ovf_q;
  logic             dz_q;

  logic [WIDTH-1:0] amag;
  logic [WIDTH-1:0] bmag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             qbit;
  logic [WIDTH-1:0] rem_d;
  logic [QW-1:0]    q_fix;
  logic [WIDTH-1:0] y_sat;
  logic             ovf_sat;

  // Magnitudes are unsigned WIDTH bits, so the most negative input maps to 2^(W-1).
  assign amag = A[WIDTH-1] ? -A : A;
  assign bmag = B[WIDTH-1] ? -B : B;

  // rem < |B| <= 2^(W-1), so the shifted remainder needs one extra bit and the
  // reduced remainder always fits back into WIDTH bits.
  assign rem_sh  = {rem_q, dq_q[QW-1]};
  assign rem_sub = rem_sh - {1'b0, bmag_q};
  assign qbit    = (rem_sh >= {1'b0, bmag_q});
  assign rem_d   = qbit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];

  always_comb begin
    q_fix = dq_q;
`ifdef FIXED_DIV_ROUND_EN
    // 2*rem >= |B| means the discarded fraction is at least one half.
    if ({rem_q, 1'b0} >= {1'b0, bmag_q}) begin
      q_fix = dq_q + QW'(1);
    end
`endif
  end

  sat_fixed #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_sat (
    .sign (sign_q),
    .q    (q_fix),
    .Y    (y_sat),
    .ovf  (ovf_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      bmag_q  <= '0;
      sign_q  <= 1'b0;
      aneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The done cycle is already IDLE; a start there is deliberately dropped.
          if (start && !done_q) begin
            dq_q    <= {amag, {FRAC{1'b0}}};
            bmag_q  <= bmag;
            rem_q   <= '0;
            sign_q  <= A[WIDTH-1] ^ B[WIDTH-1];
            aneg_q  <= A[WIDTH-1];
            bzero_q <= (B == '0);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_DIV;
          end
        end
        ST_DIV: begin
          dq_q  <= {dq_q[QW-2:0], qbit};
          rem_q <= rem_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (bzero_q) begin
            y_q   <= aneg_q ? Y_MIN : Y_MAX;
            ovf_q <= 1'b0;
            dz_q  <= 1'b1;
          end else begin
            y_q   <= y_sat;
            ovf_q <= ovf_sat;
            dz_q  <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Y    = y_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_fixed_div.sv
// Scoreboard bench for fixed_div in its default Q7.8 configuration.
module tb_fixed_div;

  localparam int unsigned LAT = 25;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] Y;
  logic        ovf;
  logic        dz;

  typedef struct {
    string       name;
    logic [15:0] y;
    logic        ovf;
    logic        dz;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  fixed_div #(
    .WIDTH (16),
    .FRAC  (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Y     (Y),
    .ovf   (ovf),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      chk("done_single_cycle", 32'(prev_done), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_Y"},   32'(Y),   32'(e.y));
        chk({e.name, "_ovf"}, 32'(ovf), 32'(e.ovf));
        chk({e.name, "_dz"},  32'(dz),  32'(e.dz));
        chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(LAT));
      end
    end
    prev_done <= done;
  end

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ey,
                       input logic eovf, input logic edz, input string nm,
                       input bit inject5, input bit start_in_done);
    exp_t e;
    int   acc;
    int   waited;
    bit   busy_bad;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    e.name = nm; e.y = ey; e.ovf = eovf; e.dz = edz; e.acc = acc;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    A = 16'h1234; B = 16'h0011;   // captured operands must not follow the inputs
    waited = 0;
    busy_bad = 1'b0;
    while (!done && waited < 40) begin
      if (!busy) busy_bad = 1'b1;
      if (inject5 && cyc == acc + 4) begin
        start = 1'b1; A = 16'h0100; B = 16'h0100;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      waited++;
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, 32'(done), 32'd1);
    chk({nm, "_busy_held"}, 32'(busy_bad), 32'd0);
    chk({nm, "_busy_low_at_done"}, 32'(busy), 32'd0);
    if (start_in_done) begin
      start = 1'b1; A = 16'h0700; B = 16'h0100;
      @(negedge clk);
      start = 1'b0;
      chk({nm, "_start_in_done_ignored"}, 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      chk({nm, "_still_idle"}, 32'(busy), 32'd0);
      chk({nm, "_Y_held"}, 32'(Y), 32'(ey));
    end
  endtask

  initial begin
    int acc;
    logic [15:0] e_round;
`ifdef FIXED_DIV_ROUND_EN
    e_round = 16'h00AB;
`else
    e_round = 16'h00AA;
`endif
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_Y",    32'(Y),    32'd0);
    chk("reset_flags", {30'd0, ovf, dz}, 32'd0);
    rst_n = 1'b1;

    do_op(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, "3_div_2_inject5", 1'b1, 1'b0);
    do_op(16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, "m3_div_2", 1'b0, 1'b1);
    do_op(16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, "min_div_1", 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0, "max_div_lsb_ovf", 1'b0, 1'b0);
    do_op(16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b1, "neg_div_zero", 1'b0, 1'b0);
    do_op(16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1, "pos_div_zero", 1'b0, 1'b0);
    do_op(16'h0200, 16'h0300, e_round,  1'b0, 1'b0, "2_div_3_round", 1'b0, 1'b0);
    do_op(16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0, "zero_div_neg", 1'b0, 1'b0);
    do_op(16'h0100, 16'hFE00, 16'hFF80, 1'b0, 1'b0, "1_div_m2", 1'b0, 1'b0);
    do_op(16'hFA00, 16'hFD00, 16'h0200, 1'b0, 1'b0, "m6_div_m3", 1'b0, 1'b0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    A = 16'h0300; B = 16'h0200; start = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc != acc + 10) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midop_reset_busy", 32'(busy), 32'd0);
    chk("midop_reset_done", 32'(done), 32'd0);
    chk("midop_reset_Y",    32'(Y),    32'd0);
    chk("midop_reset_flags", {30'd0, ovf, dz}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, "after_reset", 1'b0, 1'b0);
    do_op(16'h0600, 16'h0200, 16'h0300, 1'b0, 1'b0, "b2b_1", 1'b0, 1'b0);
    do_op(16'hFF80, 16'h0080, 16'hFF00, 1'b0, 1'b0, "b2b_2", 1'b0, 1'b0);

    repeat (30) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
